// File: rtl/acesso_memoria_dados.sv
// acesso_memoria_dados: load/store access controller, initiator side of a
// word-addressed data memory with combinational read data.
// Performs sub-word extraction with sign/zero extension on loads and a
// read-modify-write for byte/halfword stores. Misaligned, out-of-range and
// invalid-size requests are answered with resp_erro without touching memory.
//
// state      | meaning
// -----------+------------------------------------------------------------
// OCIOSO     | idle, req_pronto high, waiting for a request
// LER        | memory addressed; read data sampled at the end of the cycle
// ESCREVER   | mem_write high for this single cycle
// RESPONDER  | resp_valido high until resp_pronto is sampled high
module acesso_memoria_dados #(
    parameter int PALAVRAS = 31
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valido,
    output logic        req_pronto,
    input  logic        req_escrita,
    input  logic [1:0]  req_tamanho,
    input  logic        req_sinal,
    input  logic [31:0] req_endereco,
    input  logic [31:0] req_dado,
    output logic        resp_valido,
    input  logic        resp_pronto,
    output logic [31:0] resp_dado,
    output logic        resp_erro,
    output logic [25:0] mem_endereco,
    output logic        mem_write,
    output logic [31:0] mem_dado_escrito,
    input  logic [31:0] mem_dado_lido
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        LER       = 2'd1,
        ESCREVER  = 2'd2,
        RESPONDER = 2'd3
    } estado_t;

    localparam logic [1:0]  TAM_BYTE  = 2'b00;
    localparam logic [1:0]  TAM_MEIA  = 2'b01;
    localparam logic [1:0]  TAM_WORD  = 2'b10;
    localparam logic [1:0]  TAM_INVAL = 2'b11;
    localparam logic [31:0] LP_LIMITE = 32'(PALAVRAS);

    estado_t     r_estado;
    estado_t     w_proximo;

    logic        r_escrita;
    logic [1:0]  r_tamanho;
    logic        r_sinal;
    logic [1:0]  r_offset;
    logic [15:0] r_dado_baixo;
    logic [25:0] r_mem_endereco;
    logic [31:0] r_mem_dado_escrito;
    logic [31:0] r_resp_dado;
    logic        r_resp_erro;

    logic        w_aceite;
    logic [25:0] w_end_palavra;
    logic [1:0]  w_offset;
    logic        w_erro;
    logic        w_store_word;
    logic [7:0]  w_byte_lido;
    logic [15:0] w_meia_lida;
    logic [31:0] w_carga;
    logic [31:0] w_mesclado;

    assign w_aceite      = req_valido && (r_estado == OCIOSO);
    assign w_end_palavra = req_endereco[27:2];
    assign w_offset      = req_endereco[1:0];
    assign w_store_word  = req_escrita && (req_tamanho == TAM_WORD);

    // Reject invalid size, misalignment, upper address bits and words past the end.
    always_comb begin
        w_erro = 1'b0;
        if (req_tamanho == TAM_INVAL)
            w_erro = 1'b1;
        if ((req_tamanho == TAM_MEIA) && w_offset[0])
            w_erro = 1'b1;
        if ((req_tamanho == TAM_WORD) && (w_offset != 2'b00))
            w_erro = 1'b1;
        if (req_endereco[31:28] != 4'h0)
            w_erro = 1'b1;
        if ({6'd0, w_end_palavra} >= LP_LIMITE)
            w_erro = 1'b1;
    end

    // Lane selection and extension of the word returned by memory.
    always_comb begin
        w_byte_lido = mem_dado_lido[{r_offset, 3'b000} +: 8];
        w_meia_lida = mem_dado_lido[{r_offset[1], 4'b0000} +: 16];
        case (r_tamanho)
            TAM_BYTE: w_carga = {{24{r_sinal & w_byte_lido[7]}}, w_byte_lido};
            TAM_MEIA: w_carga = {{16{r_sinal & w_meia_lida[15]}}, w_meia_lida};
            default:  w_carga = mem_dado_lido;
        endcase
    end

    // Merge the captured store data into the word read back from memory.
    always_comb begin
        w_mesclado = mem_dado_lido;
        case (r_tamanho)
            TAM_BYTE: w_mesclado[{r_offset, 3'b000} +: 8]     = r_dado_baixo[7:0];
            TAM_MEIA: w_mesclado[{r_offset[1], 4'b0000} +: 16] = r_dado_baixo;
            default:  w_mesclado = mem_dado_lido;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_estado <= OCIOSO;
        else
            r_estado <= w_proximo;
    end

    // Next-state logic; errors skip the memory entirely.
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (req_valido) begin
                    if (w_erro)
                        w_proximo = RESPONDER;
                    else if (w_store_word)
                        w_proximo = ESCREVER;
                    else
                        w_proximo = LER;
                end
            end
            LER:       w_proximo = r_escrita ? ESCREVER : RESPONDER;
            ESCREVER:  w_proximo = RESPONDER;
            RESPONDER: w_proximo = resp_pronto ? OCIOSO : RESPONDER;
            default:   w_proximo = OCIOSO;
        endcase
    end

    // Request capture, memory-side registers and response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_escrita          <= 1'b0;
            r_tamanho          <= 2'b00;
            r_sinal            <= 1'b0;
            r_offset           <= 2'b00;
            r_dado_baixo       <= 16'h0000;
            r_mem_endereco     <= 26'd0;
            r_mem_dado_escrito <= 32'h0000_0000;
            r_resp_dado        <= 32'h0000_0000;
            r_resp_erro        <= 1'b0;
        end else begin
            if (w_aceite) begin
                r_escrita    <= req_escrita;
                r_tamanho    <= req_tamanho;
                r_sinal      <= req_sinal;
                r_offset     <= w_offset;
                r_dado_baixo <= req_dado[15:0];
                r_resp_dado  <= 32'h0000_0000;
                r_resp_erro  <= w_erro;
                // A rejected request leaves the memory-side registers untouched.
                if (!w_erro) begin
                    r_mem_endereco <= w_end_palavra;
                    if (w_store_word)
                        r_mem_dado_escrito <= req_dado;
                end
            end else if (r_estado == LER) begin
                if (r_escrita)
                    r_mem_dado_escrito <= w_mesclado;
                else
                    r_resp_dado <= w_carga;
            end
        end
    end

    assign req_pronto       = (r_estado == OCIOSO);
    assign resp_valido      = (r_estado == RESPONDER);
    assign mem_write        = (r_estado == ESCREVER);
    assign mem_endereco     = r_mem_endereco;
    assign mem_dado_escrito = r_mem_dado_escrito;
    assign resp_dado        = r_resp_dado;
    assign resp_erro        = r_resp_erro;

endmodule

// File: tb/tb_acesso_memoria_dados.sv
// Bench for acesso_memoria_dados: a behavioural memory, a request-level
// reference model with its own shadow memory, a per-cycle compare process
// and directed requests with hand-computed results.
module tb_acesso_memoria_dados;

    localparam int PALAVRAS = 31;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valido = 1'b0;
    logic        req_pronto;
    logic        req_escrita = 1'b0;
    logic [1:0]  req_tamanho = 2'b00;
    logic        req_sinal = 1'b0;
    logic [31:0] req_endereco = 32'h0;
    logic [31:0] req_dado = 32'h0;
    logic        resp_valido;
    logic        resp_pronto = 1'b1;
    logic [31:0] resp_dado;
    logic        resp_erro;
    logic [25:0] mem_endereco;
    logic        mem_write;
    logic [31:0] mem_dado_escrito;
    logic [31:0] mem_dado_lido;

    int n_total = 0;
    int n_ok    = 0;
    bit chk_on  = 1'b0;

    acesso_memoria_dados #(.PALAVRAS(PALAVRAS)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valido      (req_valido),
        .req_pronto      (req_pronto),
        .req_escrita     (req_escrita),
        .req_tamanho     (req_tamanho),
        .req_sinal       (req_sinal),
        .req_endereco    (req_endereco),
        .req_dado        (req_dado),
        .resp_valido     (resp_valido),
        .resp_pronto     (resp_pronto),
        .resp_dado       (resp_dado),
        .resp_erro       (resp_erro),
        .mem_endereco    (mem_endereco),
        .mem_write       (mem_write),
        .mem_dado_escrito(mem_dado_escrito),
        .mem_dado_lido   (mem_dado_lido)
    );

    always #5 clock = ~clock;

    // Data memory seen by the DUT.
    logic [31:0] ram [0:PALAVRAS-1];
    assign mem_dado_lido = (int'(mem_endereco) < PALAVRAS) ? ram[mem_endereco[4:0]] : 32'h0;

    always @(posedge clock) begin
        if (mem_write && int'(mem_endereco) < PALAVRAS)
            ram[mem_endereco[4:0]] <= mem_dado_escrito;
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_ok++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", nome, got, exp, $time);
    endtask

    // Reference model: one request at a time, results from plain arithmetic.
    logic [31:0] m_mem [0:PALAVRAS-1];
    bit          m_ativo = 1'b0;
    int          m_k, m_lat, m_wciclo;
    logic [31:0] m_dado, m_wdado;
    logic        m_erro;
    logic [25:0] m_wend;

    task automatic modelo_aceitar();
        int          sh;
        logic [31:0] w, mask, v;
        logic        sbit;
        sh       = 8 * int'(req_endereco[1:0]);
        m_erro   = (req_tamanho == 2'b11) ||
                   (req_tamanho == 2'b01 && req_endereco[0]) ||
                   (req_tamanho == 2'b10 && req_endereco[1:0] != 2'b00) ||
                   (req_endereco[31:28] != 4'h0) ||
                   (int'(req_endereco[27:2]) >= PALAVRAS);
        m_dado   = 32'h0;
        m_wciclo = 0;
        if (m_erro) begin
            m_lat = 1;
        end else begin
            m_wend = req_endereco[27:2];
            w      = m_mem[m_wend[4:0]];
            mask   = (req_tamanho == 2'b00) ? 32'h0000_00FF :
                     (req_tamanho == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            if (!req_escrita) begin
                v    = (w >> sh) & mask;
                sbit = (req_tamanho == 2'b00) ? v[7] : v[15];
                if (req_sinal && req_tamanho != 2'b10 && sbit)
                    v = v | ~mask;
                m_dado = v;
                m_lat  = 2;
            end else begin
                m_wdado  = (w & ~(mask << sh)) | ((req_dado & mask) << sh);
                m_lat    = (req_tamanho == 2'b10) ? 2 : 3;
                m_wciclo = m_lat - 1;
            end
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ativo = 1'b0;
        end else if (!m_ativo) begin
            if (req_valido) begin
                modelo_aceitar();
                m_ativo = 1'b1;
                m_k     = 1;
            end
        end else begin
            if (m_k == m_wciclo)
                m_mem[m_wend[4:0]] = m_wdado;
            if (m_k >= m_lat && resp_pronto)
                m_ativo = 1'b0;
            else
                m_k++;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (reset_n && chk_on) begin
            chk("req_pronto", 32'(req_pronto), 32'(!m_ativo));
            chk("resp_valido", 32'(resp_valido), 32'(m_ativo && m_k >= m_lat));
            chk("mem_write", 32'(mem_write), 32'(m_ativo && m_k == m_wciclo));
            if (m_ativo && m_k >= m_lat) begin
                chk("resp_dado", resp_dado, m_dado);
                chk("resp_erro", 32'(resp_erro), 32'(m_erro));
            end
            if (m_ativo && m_k == m_wciclo) begin
                chk("mem_endereco", 32'(mem_endereco), 32'(m_wend));
                chk("mem_dado_escrito", mem_dado_escrito, m_wdado);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, " req_pronto"}, 32'(req_pronto), 32'd1);
        chk({tag, " resp_valido"}, 32'(resp_valido), 32'd0);
        chk({tag, " resp_dado"}, resp_dado, 32'h0);
        chk({tag, " resp_erro"}, 32'(resp_erro), 32'd0);
        chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, " mem_endereco"}, 32'(mem_endereco), 32'd0);
        chk({tag, " mem_dado_escrito"}, mem_dado_escrito, 32'h0);
    endtask

    task automatic req(input string nome, input logic escrita, input logic [1:0] tam,
                       input logic sinal, input logic [31:0] endereco, input logic [31:0] dado,
                       input int espera, input logic [31:0] lit_dado, input logic lit_erro,
                       input int lit_lat);
        int n;
        bit achou;
        @(negedge clock);
        req_valido   = 1'b1;
        req_escrita  = escrita;
        req_tamanho  = tam;
        req_sinal    = sinal;
        req_endereco = endereco;
        req_dado     = dado;
        resp_pronto  = (espera == 0);
        @(posedge clock);
        n     = 0;
        achou = 1'b0;
        while (n < 20 && !achou) begin
            @(negedge clock);
            if (n == 0) begin
                req_valido   = 1'b0;
                req_dado     = ~dado;
                req_endereco = endereco ^ 32'h0000_0044;
                req_sinal    = ~sinal;
            end
            n++;
            if (resp_valido) achou = 1'b1;
        end
        if (!achou) begin
            chk({nome, " timeout"}, 32'(n), 32'(lit_lat));
            return;
        end
        chk({nome, " latency"}, 32'(n), 32'(lit_lat));
        chk({nome, " resp_dado"}, resp_dado, lit_dado);
        chk({nome, " resp_erro"}, 32'(resp_erro), 32'(lit_erro));
        chk({nome, " model"}, m_dado, lit_dado);
        if (espera > 0) begin
            // A request presented while busy must be ignored.
            req_valido   = 1'b1;
            req_escrita  = 1'b1;
            req_tamanho  = 2'b10;
            req_endereco = 32'h0000_0000;
            req_dado     = 32'h1111_1111;
            for (int i = 0; i < espera; i++) begin
                @(negedge clock);
                chk({nome, " hold valid"}, 32'(resp_valido), 32'd1);
                chk({nome, " hold dado"}, resp_dado, lit_dado);
                chk({nome, " hold pronto"}, 32'(req_pronto), 32'd0);
            end
            resp_pronto = 1'b1;
            req_valido  = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < PALAVRAS; i++) begin
            ram[i]   = 32'hAAAA_AAAA;
            m_mem[i] = 32'hAAAA_AAAA;
        end
        ram[1]    = 32'h80F0_7F01;
        m_mem[1]  = 32'h80F0_7F01;
        ram[30]   = 32'h0BAD_F00D;
        m_mem[30] = 32'h0BAD_F00D;

        #12;
        check_reset_vals("reset");
        @(negedge clock);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        req("st_w 08",   1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 0, 32'h0,         0, 2);
        req("ld_w 08",   0, 2'b10, 0, 32'h08, 32'h0,         0, 32'hDEAD_BEEF, 0, 2);
        req("ld_b 07 s", 0, 2'b00, 1, 32'h07, 32'h0,         0, 32'hFFFF_FF80, 0, 2);
        req("ld_b 07 u", 0, 2'b00, 0, 32'h07, 32'h0,         0, 32'h0000_0080, 0, 2);
        req("ld_b 06 s", 0, 2'b00, 1, 32'h06, 32'h0,         0, 32'hFFFF_FFF0, 0, 2);
        req("ld_h 04 s", 0, 2'b01, 1, 32'h04, 32'h0,         0, 32'h0000_7F01, 0, 2);
        req("ld_h 06 s", 0, 2'b01, 1, 32'h06, 32'h0,         0, 32'hFFFF_80F0, 0, 2);
        req("ld_h 06 u", 0, 2'b01, 0, 32'h06, 32'h0,         0, 32'h0000_80F0, 0, 2);
        req("st_w 04",   1, 2'b10, 0, 32'h04, 32'hAAAA_AAAA, 0, 32'h0,         0, 2);
        req("st_h 06",   1, 2'b01, 0, 32'h06, 32'hFFFF_1234, 0, 32'h0,         0, 3);
        req("ld_w 04",   0, 2'b10, 0, 32'h04, 32'h0,         0, 32'h1234_AAAA, 0, 2);
        req("st_b 09",   1, 2'b00, 0, 32'h09, 32'h0000_0077, 0, 32'h0,         0, 3);
        req("ld_w 08b",  0, 2'b10, 0, 32'h08, 32'h0,         0, 32'hDEAD_77EF, 0, 2);
        req("ld_b 09 u", 0, 2'b00, 0, 32'h09, 32'h0,         0, 32'h0000_0077, 0, 2);
        req("err ld_w 02", 0, 2'b10, 0, 32'h02,        32'h0,   0, 32'h0, 1, 1);
        req("err st_h 05", 1, 2'b01, 0, 32'h05,        32'h55,  0, 32'h0, 1, 1);
        req("err tam 11",  0, 2'b11, 0, 32'h00,        32'h0,   0, 32'h0, 1, 1);
        req("err ld_w 7C", 0, 2'b10, 0, 32'h7C,        32'h0,   0, 32'h0, 1, 1);
        req("err hi addr", 1, 2'b10, 0, 32'h1000_0000, 32'h99,  0, 32'h0, 1, 1);
        req("ld_w 78",   0, 2'b10, 0, 32'h78, 32'h0,         0, 32'h0BAD_F00D, 0, 2);
        req("bp ld_w 08", 0, 2'b10, 0, 32'h08, 32'h0,        5, 32'hDEAD_77EF, 0, 2);
        req("ld_w 00",   0, 2'b10, 0, 32'h00, 32'h0,         0, 32'hAAAA_AAAA, 0, 2);

        // Reset while ESCREVER is active: write must not land.
        @(negedge clock);
        req_valido   = 1'b1;
        req_escrita  = 1'b1;
        req_tamanho  = 2'b10;
        req_endereco = 32'h10;
        req_dado     = 32'h5555_5555;
        @(posedge clock);
        #1;
        chk("rst pre mem_write", 32'(mem_write), 32'd1);
        chk("rst pre mem_dado_escrito", mem_dado_escrito, 32'h5555_5555);
        req_valido = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst mid");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        req("ld_w 10",   0, 2'b10, 0, 32'h10, 32'h0,         0, 32'hAAAA_AAAA, 0, 2);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
